sram_banked_2p: RTL and testbench

- Parametrised, multi-bank memory built from NUM_BANKS GF180_RAM_512x32 macros; each macro is single-ported.
- Presents one read/write port (port 0) and one read-only port (port 1) to the management SoC.
- A per-bank arbiter resolves same-bank conflicts. A starvation guard ensures port 1 makes progress.
- Successor to the single-macro 512x32 wrapper; adds depth scaling, address interleaving and a true second port.

---
 rtl/sram_banked_pkg.sv | 23 ++
 rtl/GF180_RAM_512x32.sv | 31 +++
 rtl/sram_bank_arb.sv | 40 ++++
 rtl/sram_banked_2p.sv | 150 +++++++++++++++
 tb/tb_sram_banked_2p.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_banked_pkg.sv
// Shared constants, helpers and types for the banked two-port SRAM.
package sram_banked_pkg;

  // Geometry of one GF180_RAM_512x32 macro
  localparam int BANK_AW = 9;
  localparam int BANK_DW = 32;
  localparam int BANK_WM = 4;

  // Ceiling log2; returns 0 for an argument of 1
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // Which requester owns a bank in a given cycle
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_e;

endpackage

// File: rtl/GF180_RAM_512x32.sv
// Behavioural model of the single-ported 512x32 macro.
// CEN high selects the macro, GWEN low writes, WEN is a per-byte active-low mask.
// Q holds the last word read; contents are never cleared.
module GF180_RAM_512x32
  import sram_banked_pkg::*;
(
  input  logic               CLK,
  input  logic               CEN,
  input  logic               GWEN,
  input  logic [BANK_WM-1:0] WEN,
  input  logic [BANK_AW-1:0] A,
  input  logic [BANK_DW-1:0] D,
  output logic [BANK_DW-1:0] Q
);

  logic [BANK_DW-1:0] mem [2**BANK_AW];

  // Synchronous byte-masked write or registered read
  always_ff @(posedge CLK) begin
    if (CEN) begin
      if (!GWEN) begin
        for (int i = 0; i < BANK_WM; i++) begin
          if (!WEN[i]) mem[A][8*i +: 8] <= D[8*i +: 8];
        end
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/sram_bank_arb.sv
// Per-bank arbiter between port 0 (read/write) and port 1 (read-only).
// Port 0 wins conflicts until port 1 has lost STARVE_LIMIT in a row,
// then port 1 wins once and the counter clears.
module sram_bank_arb
  import sram_banked_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     hit0,
  input  logic     hit1,
  output logic     gnt,
  output port_id_e port
);

  logic [3:0] starve_cnt;
  logic       conflict;
  logic       starved;

  // Grant decision for this cycle
  always_comb begin
    conflict = hit0 && hit1;
    starved  = (starve_cnt == 4'(STARVE_LIMIT));
    gnt      = hit0 || hit1;
    port     = (hit1 && (!hit0 || starved)) ? PORT1 : PORT0;
  end

  // Count consecutive conflicts lost by port 1, saturating at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (gnt && (port == PORT1)) begin
      starve_cnt <= '0;
    end else if (conflict && !starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/sram_banked_2p.sv
// Multi-bank memory with one read/write port and one read-only port.
// Optional macro SRAM_BANKED_OUTREG_EN adds an output register after the
// bank mux (read latency 2 instead of 1).
module sram_banked_2p
  import sram_banked_pkg::clog2;
  import sram_banked_pkg::port_id_e;
  import sram_banked_pkg::PORT0;
  import sram_banked_pkg::PORT1;
#(
  parameter int NUM_BANKS    = 2,
  parameter int BANK_AW      = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_WMASKS   = 4,
  parameter int INTERLEAVE   = 1,
  parameter int STARVE_LIMIT = 3,
  localparam int BSW        = clog2(NUM_BANKS),
  localparam int ADDR_WIDTH = BANK_AW + BSW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  output logic                  p0_gnt,
  input  logic                  p0_we,
  input  logic [NUM_WMASKS-1:0] p0_wmask,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  output logic                  p1_gnt,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata
);

  localparam int BW = (BSW > 0) ? BSW : 1;

  logic [1:0]            rst_q;
  logic                  rst_i;
  logic                  p0_req_i, p1_req_i;
  logic [BW-1:0]         p0_bank, p1_bank;
  logic [BANK_AW-1:0]    p0_row, p1_row;
  logic [NUM_BANKS-1:0]  bank_p0_gnt, bank_p1_gnt;
  logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];
  logic                  p0_rv_q, p1_rv_q;
  logic [BW-1:0]         p0_bank_q, p1_bank_q;
  logic [DATA_WIDTH-1:0] p0_mux, p1_mux;

  // Reset asserts immediately and releases on clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_q <= 2'b11;
    else     rst_q <= {rst_q[0], 1'b0};
  end

  assign rst_i    = rst_q[1];
  assign p0_req_i = p0_req && !rst_i;
  assign p1_req_i = p1_req && !rst_i;

  if (NUM_BANKS == 1) begin : g_split_one
    assign p0_bank = '0;
    assign p1_bank = '0;
    assign p0_row  = p0_addr;
    assign p1_row  = p1_addr;
  end else if (INTERLEAVE != 0) begin : g_split_lsb
    assign p0_bank = p0_addr[BSW-1:0];
    assign p1_bank = p1_addr[BSW-1:0];
    assign p0_row  = p0_addr[ADDR_WIDTH-1:BSW];
    assign p1_row  = p1_addr[ADDR_WIDTH-1:BSW];
  end else begin : g_split_msb
    assign p0_bank = p0_addr[ADDR_WIDTH-1 -: BSW];
    assign p1_bank = p1_addr[ADDR_WIDTH-1 -: BSW];
    assign p0_row  = p0_addr[BANK_AW-1:0];
    assign p1_row  = p1_addr[BANK_AW-1:0];
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic     hit0, hit1, gnt, p0_sel, wr;
    port_id_e port;

    assign hit0   = p0_req_i && (p0_bank == BW'(b));
    assign hit1   = p1_req_i && (p1_bank == BW'(b));
    assign p0_sel = gnt && (port == PORT0);
    assign wr     = p0_sel && p0_we;
    assign bank_p0_gnt[b] = p0_sel;
    assign bank_p1_gnt[b] = gnt && (port == PORT1);

    sram_bank_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
      .clk  (clk),
      .rst  (rst_i),
      .hit0 (hit0),
      .hit1 (hit1),
      .gnt  (gnt),
      .port (port)
    );

    GF180_RAM_512x32 u_ram (
      .CLK  (clk),
      .CEN  (gnt),
      .GWEN (~wr),
      .WEN  (wr ? ~p0_wmask : '1),
      .A    (p0_sel ? p0_row : p1_row),
      .D    (p0_wdata),
      .Q    (bank_q[b])
    );
  end

  assign p0_gnt = |bank_p0_gnt;
  assign p1_gnt = |bank_p1_gnt;

  // Remember which reads were accepted and which bank will answer
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      p0_rv_q   <= 1'b0;
      p1_rv_q   <= 1'b0;
      p0_bank_q <= '0;
      p1_bank_q <= '0;
    end else begin
      p0_rv_q   <= p0_gnt && !p0_we;
      p1_rv_q   <= p1_gnt;
      p0_bank_q <= p0_bank;
      p1_bank_q <= p1_bank;
    end
  end

  assign p0_mux = p0_rv_q ? bank_q[p0_bank_q] : '0;
  assign p1_mux = p1_rv_q ? bank_q[p1_bank_q] : '0;

`ifdef SRAM_BANKED_OUTREG_EN
  // Extra register stage after the bank mux
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= p0_rv_q;
      p1_rvalid <= p1_rv_q;
      p0_rdata  <= p0_mux;
      p1_rdata  <= p1_mux;
    end
  end
`else
  assign p0_rvalid = p0_rv_q;
  assign p1_rvalid = p1_rv_q;
  assign p0_rdata  = p0_mux;
  assign p1_rdata  = p1_mux;
`endif

endmodule

// File: tb/tb_sram_banked_2p.sv
// Directed bench for sram_banked_2p (NUM_BANKS=2, INTERLEAVE=1, STARVE_LIMIT=3).
// Build with SRAM_BANKED_OUTREG_EN defined to exercise the 2-cycle read path.
module tb_sram_banked_2p;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [3:0]  p0_wmask = '0;
  logic [9:0]  p0_addr = '0;
  logic [31:0] p0_wdata = '0;
  logic        p0_gnt, p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_req = 1'b0;
  logic [9:0]  p1_addr = '0;
  logic        p1_gnt, p1_rvalid;
  logic [31:0] p1_rdata;

  int tests = 0;
  int fails = 0;

  sram_banked_2p dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_gnt(p0_gnt), .p0_we(p0_we), .p0_wmask(p0_wmask),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_gnt(p1_gnt), .p1_addr(p1_addr),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Extra cycle of read latency when the output register is present
  task automatic lat_pad();
`ifdef SRAM_BANKED_OUTREG_EN
    cyc();
`endif
  endtask

  task automatic p0_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = a; p0_wdata = d; p0_wmask = m;
    cyc();
    p0_req = 1'b0; p0_we = 1'b0; p0_wmask = '0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (3) cyc();
    tests++; if (p0_rvalid !== 1'b0) begin fails++; $display("FAIL rst_p0_rvalid got %0b want 0", p0_rvalid); end
    tests++; if (p1_rvalid !== 1'b0) begin fails++; $display("FAIL rst_p1_rvalid got %0b want 0", p1_rvalid); end
    rst = 1'b0;
    repeat (3) cyc();
    tests++; if (p0_rdata !== 32'h0) begin fails++; $display("FAIL rst_p0_rdata got %08h want 0", p0_rdata); end
    tests++; if (p1_rdata !== 32'h0) begin fails++; $display("FAIL rst_p1_rdata got %08h want 0", p1_rdata); end
  endtask

  task automatic test_write_read();
    p0_write(10'd4, 32'hDEADBEEF, 4'hF);
    tests++; if (p0_rvalid !== 1'b0) begin fails++; $display("FAIL wr_no_rvalid got %0b want 0", p0_rvalid); end
    p0_addr = 10'd4; p0_req = 1'b1;
    #1;
    tests++; if (p0_gnt !== 1'b1) begin fails++; $display("FAIL rd4_gnt got %0b want 1", p0_gnt); end
    cyc();
    p0_req = 1'b0;
`ifdef SRAM_BANKED_OUTREG_EN
    tests++; if (p0_rvalid !== 1'b0) begin fails++; $display("FAIL rd4_early got %0b want 0", p0_rvalid); end
`endif
    lat_pad();
    tests++; if (p0_rvalid !== 1'b1) begin fails++; $display("FAIL rd4_rvalid got %0b want 1", p0_rvalid); end
    tests++; if (p0_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd4_rdata got %08h want deadbeef", p0_rdata); end
    cyc();
    tests++; if (p0_rvalid !== 1'b0) begin fails++; $display("FAIL rd4_pulse got %0b want 0", p0_rvalid); end
  endtask

  task automatic test_partial_write();
    p0_write(10'd6, 32'h11223344, 4'hF);
    p0_write(10'd6, 32'hAABBCCDD, 4'h2);
    p0_addr = 10'd6; p0_req = 1'b1;
    cyc();
    p0_req = 1'b0;
    lat_pad();
    tests++; if (p0_rdata !== 32'h1122CC44) begin fails++; $display("FAIL partial_rdata got %08h want 1122cc44", p0_rdata); end
  endtask

  task automatic test_diff_banks();
    p0_write(10'd2, 32'hA5A50002, 4'hF);
    p0_write(10'd3, 32'h5A5A0003, 4'hF);
    p0_addr = 10'd2; p0_req = 1'b1;
    p1_addr = 10'd3; p1_req = 1'b1;
    #1;
    tests++; if (p0_gnt !== 1'b1) begin fails++; $display("FAIL diff_p0_gnt got %0b want 1", p0_gnt); end
    tests++; if (p1_gnt !== 1'b1) begin fails++; $display("FAIL diff_p1_gnt got %0b want 1", p1_gnt); end
    cyc();
    p0_req = 1'b0; p1_req = 1'b0;
    lat_pad();
    tests++; if (p0_rvalid !== 1'b1) begin fails++; $display("FAIL diff_p0_rvalid got %0b want 1", p0_rvalid); end
    tests++; if (p0_rdata !== 32'hA5A50002) begin fails++; $display("FAIL diff_p0_rdata got %08h want a5a50002", p0_rdata); end
    tests++; if (p1_rvalid !== 1'b1) begin fails++; $display("FAIL diff_p1_rvalid got %0b want 1", p1_rvalid); end
    tests++; if (p1_rdata !== 32'h5A5A0003) begin fails++; $display("FAIL diff_p1_rdata got %08h want 5a5a0003", p1_rdata); end
  endtask

  task automatic test_starvation();
    p0_write(10'd0, 32'h0BADF00D, 4'hF);
    p0_addr = 10'd0; p0_req = 1'b1;
    p1_addr = 10'd0; p1_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      tests++; if (p0_gnt !== 1'b1) begin fails++; $display("FAIL starve_c%0d_p0_gnt got %0b want 1", i, p0_gnt); end
      tests++; if (p1_gnt !== 1'b0) begin fails++; $display("FAIL starve_c%0d_p1_gnt got %0b want 0", i, p1_gnt); end
      cyc();
    end
    #1;
    tests++; if (p1_gnt !== 1'b1) begin fails++; $display("FAIL starve_c4_p1_gnt got %0b want 1", p1_gnt); end
    tests++; if (p0_gnt !== 1'b0) begin fails++; $display("FAIL starve_c4_p0_gnt got %0b want 0", p0_gnt); end
    cyc();
    p0_req = 1'b0; p1_req = 1'b0;
    lat_pad();
    tests++; if (p1_rvalid !== 1'b1) begin fails++; $display("FAIL starve_p1_rvalid got %0b want 1", p1_rvalid); end
    tests++; if (p1_rdata !== 32'h0BADF00D) begin fails++; $display("FAIL starve_p1_rdata got %08h want 0badf00d", p1_rdata); end
    tests++; if (p0_rvalid !== 1'b0) begin fails++; $display("FAIL starve_p0_rvalid got %0b want 0", p0_rvalid); end
  endtask

  task automatic test_same_addr();
    p0_write(10'd8, 32'h11111111, 4'hF);
    p0_addr = 10'd8; p0_we = 1'b1; p0_wdata = 32'h87654321; p0_wmask = 4'hF; p0_req = 1'b1;
    p1_addr = 10'd8; p1_req = 1'b1;
    #1;
    tests++; if (p0_gnt !== 1'b1) begin fails++; $display("FAIL same_p0_gnt got %0b want 1", p0_gnt); end
    tests++; if (p1_gnt !== 1'b0) begin fails++; $display("FAIL same_p1_gnt got %0b want 0", p1_gnt); end
    cyc();
    p0_req = 1'b0; p0_we = 1'b0; p0_wmask = '0;
    #1;
    tests++; if (p1_gnt !== 1'b1) begin fails++; $display("FAIL same_p1_gnt2 got %0b want 1", p1_gnt); end
    cyc();
    p1_req = 1'b0;
    lat_pad();
    tests++; if (p1_rvalid !== 1'b1) begin fails++; $display("FAIL same_p1_rvalid got %0b want 1", p1_rvalid); end
    tests++; if (p1_rdata !== 32'h87654321) begin fails++; $display("FAIL same_p1_rdata got %08h want 87654321", p1_rdata); end
  endtask

  task automatic test_back_to_back();
    logic        sv [3];
    logic [31:0] sd [3];
    logic        ev [3];
    logic [31:0] ed [3];
`ifdef SRAM_BANKED_OUTREG_EN
    ev = '{1'b0, 1'b1, 1'b1};
    ed = '{32'h0, 32'hDEADBEEF, 32'h1122CC44};
`else
    ev = '{1'b1, 1'b1, 1'b0};
    ed = '{32'hDEADBEEF, 32'h1122CC44, 32'h0};
`endif
    p0_addr = 10'd4; p0_req = 1'b1;
    #1;
    tests++; if (p0_gnt !== 1'b1) begin fails++; $display("FAIL b2b_gnt0 got %0b want 1", p0_gnt); end
    cyc();
    sv[0] = p0_rvalid; sd[0] = p0_rdata;
    p0_addr = 10'd6;
    #1;
    tests++; if (p0_gnt !== 1'b1) begin fails++; $display("FAIL b2b_gnt1 got %0b want 1", p0_gnt); end
    cyc();
    sv[1] = p0_rvalid; sd[1] = p0_rdata;
    p0_req = 1'b0;
    cyc();
    sv[2] = p0_rvalid; sd[2] = p0_rdata;
    for (int i = 0; i < 3; i++) begin
      tests++; if (sv[i] !== ev[i]) begin fails++; $display("FAIL b2b_rvalid%0d got %0b want %0b", i, sv[i], ev[i]); end
      tests++; if (sd[i] !== ed[i]) begin fails++; $display("FAIL b2b_rdata%0d got %08h want %08h", i, sd[i], ed[i]); end
    end
  endtask

  task automatic test_reset_mid();
    p1_addr = 10'd4; p1_req = 1'b1;
    #1;
    tests++; if (p1_gnt !== 1'b1) begin fails++; $display("FAIL rmid_p1_gnt got %0b want 1", p1_gnt); end
    @(posedge clk);
    #1 rst = 1'b1; p1_req = 1'b0;
    #1;
    tests++; if (p1_rvalid !== 1'b0) begin fails++; $display("FAIL rmid_p1_rvalid got %0b want 0", p1_rvalid); end
    tests++; if (p1_rdata !== 32'h0) begin fails++; $display("FAIL rmid_p1_rdata got %08h want 0", p1_rdata); end
    cyc();
    tests++; if (p1_rvalid !== 1'b0) begin fails++; $display("FAIL rmid_p1_rvalid2 got %0b want 0", p1_rvalid); end
    rst = 1'b0;
    repeat (3) cyc();
    tests++; if (p1_rvalid !== 1'b0) begin fails++; $display("FAIL rmid_post_rvalid got %0b want 0", p1_rvalid); end
    p0_addr = 10'd4; p0_req = 1'b1;
    cyc();
    p0_req = 1'b0;
    lat_pad();
    tests++; if (p0_rvalid !== 1'b1) begin fails++; $display("FAIL rmid_keep_rvalid got %0b want 1", p0_rvalid); end
    tests++; if (p0_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rmid_keep_rdata got %08h want deadbeef", p0_rdata); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_diff_banks();
    test_starvation();
    test_same_addr();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
